// File: rtl/matmul_c_drain.sv
// Reads matrix C back row by row and serializes each row into OUT_LANES-element stream words.
// Latency: start -> first out_valid = 1 + READ_LATENCY + 1 cycles; each row costs 1+READ_LATENCY+WPR cycles.
// Backpressure: out_valid/out_data hold until out_ready; optional out_last under MATMUL_DRAIN_LAST_EN.
module matmul_c_drain #(
    parameter int DWIDTH       = 16,
    parameter int MAT_SIZE     = 32,
    parameter int AWIDTH       = 7,
    parameter int NUM_ROWS     = 32,
    parameter int OUT_LANES    = 4,
    parameter int READ_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          enable_reading_from_mem,
    output logic [AWIDTH-1:0]             addr_pi,
    input  logic [MAT_SIZE*DWIDTH-1:0]    data_from_out_mat,
    output logic [OUT_LANES*DWIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef MATMUL_DRAIN_LAST_EN
    output logic                          out_last,
`endif
    output logic                          busy,
    output logic                          drain_done
);

    localparam int RW  = MAT_SIZE * DWIDTH;
    localparam int OW  = OUT_LANES * DWIDTH;
    localparam int WPR = MAT_SIZE / OUT_LANES;
    localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int LW  = $clog2(READ_LATENCY + 1);

    localparam logic [WW-1:0]     LAST_WORD = WW'(WPR - 1);
    localparam logic [AWIDTH-1:0] LAST_ROW  = AWIDTH'(NUM_ROWS - 1);
    localparam logic [LW-1:0]     LAST_LAT  = LW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] row;
    logic [WW-1:0]     word;
    logic [LW-1:0]     lat_cnt;
    // Holds the words of the current row not yet presented on out_data.
    logic [RW-1:0]     buffer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            row                     <= '0;
            word                    <= '0;
            lat_cnt                 <= '0;
            buffer                  <= '0;
            enable_reading_from_mem <= 1'b0;
            addr_pi                 <= '0;
            out_data                <= '0;
            out_valid               <= 1'b0;
            busy                    <= 1'b0;
            drain_done              <= 1'b0;
`ifdef MATMUL_DRAIN_LAST_EN
            out_last                <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy                    <= 1'b1;
                        enable_reading_from_mem <= 1'b1;
                        row                     <= '0;
                        addr_pi                 <= '0;
                        state                   <= ISSUE;
                    end
                end
                ISSUE: begin
                    addr_pi <= row;
                    lat_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Address was presented in ISSUE; data is good after READ_LATENCY edges.
                    if (lat_cnt == LAST_LAT) begin
                        out_data  <= data_from_out_mat[OW-1:0];
                        buffer    <= data_from_out_mat >> OW;
                        out_valid <= 1'b1;
                        word      <= '0;
`ifdef MATMUL_DRAIN_LAST_EN
                        out_last  <= (row == LAST_ROW) && (WPR == 1);
`endif
                        state     <= SHIFT;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (out_valid && out_ready) begin
                        if (word == LAST_WORD) begin
                            out_valid <= 1'b0;
`ifdef MATMUL_DRAIN_LAST_EN
                            out_last  <= 1'b0;
`endif
                            if (row == LAST_ROW) begin
                                drain_done              <= 1'b1;
                                busy                    <= 1'b0;
                                enable_reading_from_mem <= 1'b0;
                                addr_pi                 <= '0;
                                state                   <= DONE;
                            end else begin
                                row     <= row + 1'b1;
                                addr_pi <= row + 1'b1;
                                state   <= ISSUE;
                            end
                        end else begin
                            word     <= word + 1'b1;
                            out_data <= buffer[OW-1:0];
                            buffer   <= buffer >> OW;
`ifdef MATMUL_DRAIN_LAST_EN
                            out_last <= (row == LAST_ROW) && ((word + 1'b1) == LAST_WORD);
`endif
                        end
                    end
                end
                DONE: begin
                    drain_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_c_drain.sv
// Directed bench: RAM model C[r][e] = r*32+e with registered read pipeline; checks stream order, timing, reset abort.
module tb_matmul_c_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start, out_ready;
    logic         enable_reading_from_mem, out_valid, busy, drain_done;
    logic [6:0]   addr_pi;
    logic [511:0] data_from_out_mat;
    logic [63:0]  out_data;
    logic         we_c;
`ifdef MATMUL_DRAIN_LAST_EN
    logic         out_last, out_last_w;
`endif

    logic         start_w, out_ready_w;
    logic         enable_w, out_valid_w, busy_w, drain_done_w;
    logic [6:0]   addr_w;
    logic [511:0] data_w, out_data_w;

    int checks = 0;
    int errors = 0;

    matmul_c_drain u_dut (
        .clk(clk), .reset(reset), .start(start),
        .enable_reading_from_mem(enable_reading_from_mem), .addr_pi(addr_pi),
        .data_from_out_mat(data_from_out_mat), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef MATMUL_DRAIN_LAST_EN
        .out_last(out_last),
`endif
        .busy(busy), .drain_done(drain_done)
    );

    matmul_c_drain #(.OUT_LANES(32), .READ_LATENCY(5)) u_wide (
        .clk(clk), .reset(reset), .start(start_w),
        .enable_reading_from_mem(enable_w), .addr_pi(addr_w),
        .data_from_out_mat(data_w), .out_data(out_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
`ifdef MATMUL_DRAIN_LAST_EN
        .out_last(out_last_w),
`endif
        .busy(busy_w), .drain_done(drain_done_w)
    );

    function automatic logic [511:0] row_val(input logic [6:0] r);
        logic [511:0] v;
        for (int e = 0; e < 32; e++) v[e*16 +: 16] = 16'(int'(r) * 32 + e);
        return v;
    endfunction

    function automatic logic [63:0] word_val(input int k);
        logic [63:0] v;
        for (int l = 0; l < 4; l++) v[l*16 +: 16] = 16'(4 * k + l);
        return v;
    endfunction

    // C RAM read paths: addr reg + mux reg + RAM (3 edges), and a 5-edge path for the wide instance.
    logic [6:0] p1, p2, q1, q2, q3, q4;
    always_ff @(posedge clk) begin
        p1 <= addr_pi;
        p2 <= p1;
        data_from_out_mat <= row_val(p2);
        q1 <= addr_w;
        q2 <= q1;
        q3 <= q2;
        q4 <= q3;
        data_w <= row_val(q4);
    end

    assign we_c = 1'b0;
    always @(posedge clk) if (busy) assert (!we_c) else $error("we_c high while busy");

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_en"}, 512'(enable_reading_from_mem), 512'(0));
        chk({nm, "_addr"}, 512'(addr_pi), 512'(0));
        chk({nm, "_data"}, 512'(out_data), 512'(0));
        chk({nm, "_valid"}, 512'(out_valid), 512'(0));
        chk({nm, "_busy"}, 512'(busy), 512'(0));
        chk({nm, "_done"}, 512'(drain_done), 512'(0));
`ifdef MATMUL_DRAIN_LAST_EN
        chk({nm, "_last"}, 512'(out_last), 512'(0));
`endif
    endtask

    task automatic run_drain(input string nm, input int pct, input bit repulse,
                             input int exp_first, input int exp_done);
        int cyc, idx, first, done_cyc, ndone;
        bit stall;
        logic [63:0] held;
        idx = 0; first = 0; done_cyc = 0; ndone = 0; stall = 0; held = '0;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        chk({nm, "_busy_c1"}, 512'(busy), 512'(1));
        chk({nm, "_en_c1"}, 512'(enable_reading_from_mem), 512'(1));
        chk({nm, "_addr_c1"}, 512'(addr_pi), 512'(0));
        while (cyc < 3000 && !(ndone > 0 && cyc > done_cyc + 3)) begin
            if (stall) begin
                chk({nm, "_hold_valid"}, 512'(out_valid), 512'(1));
                chk({nm, "_hold_data"}, 512'(out_data), 512'(held));
            end
            if (out_valid && first == 0) first = cyc;
            out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            start = repulse && (cyc == 3 || cyc == 40 || drain_done);
            if (drain_done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
                chk({nm, "_busy_at_done"}, 512'(busy), 512'(0));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("%s_word%0d", nm, idx), 512'(out_data), 512'(word_val(idx)));
`ifdef MATMUL_DRAIN_LAST_EN
                chk($sformatf("%s_last%0d", nm, idx), 512'(out_last), 512'(idx == 255));
`endif
                idx++;
            end
            stall = out_valid && !out_ready;
            held = out_data;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        chk({nm, "_nwords"}, 512'(idx), 512'(256));
        chk({nm, "_ndone"}, 512'(ndone), 512'(1));
        chk({nm, "_first_valid"}, 512'(first), 512'(exp_first));
        if (exp_done != 0) chk({nm, "_done_cycle"}, 512'(done_cyc), 512'(exp_done));
        chk({nm, "_busy_after"}, 512'(busy), 512'(0));
        chk({nm, "_valid_after"}, 512'(out_valid), 512'(0));
    endtask

    typedef struct {
        string name;
        int    ready_pct;
        bit    repulse;
        int    exp_first;
        int    exp_done;
    } scen_t;

    initial begin
        scen_t scen[3];
        int cyc, idx, first, done_cyc, ndone;
        bit found;

        scen[0] = '{"ready1", 100, 1'b0, 5, 385};
        scen[1] = '{"rand50", 50, 1'b0, 5, 0};
        scen[2] = '{"repulse", 100, 1'b1, 5, 385};

        reset = 1'b1; start = 1'b0; out_ready = 1'b1; start_w = 1'b0; out_ready_w = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_wide_valid", 512'(out_valid_w), 512'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            run_drain(scen[i].name, scen[i].ready_pct, scen[i].repulse,
                      scen[i].exp_first, scen[i].exp_done);
            repeat (2) @(posedge clk);
            #1;
        end

        // Abort while row 5 word 2 (stream word 42) is on the bus.
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            if (out_valid && out_data == word_val(42)) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("abort_reached_word42", 512'(found), 512'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        reset = 1'b0;
        @(posedge clk); #1;
        run_drain("after_abort", 100, 1'b0, 5, 385);

        // Wide instance: one word per row, 5-cycle read latency.
        idx = 0; first = 0; done_cyc = 0; ndone = 0;
        start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0; cyc = 1;
        while (cyc < 1000 && !(ndone > 0 && cyc > done_cyc + 2)) begin
            if (out_valid_w && first == 0) first = cyc;
            if (drain_done_w) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (out_valid_w && out_ready_w) begin
                chk($sformatf("wide_row%0d", idx), out_data_w, row_val(7'(idx)));
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("wide_first_valid", 512'(first), 512'(7));
        chk("wide_nwords", 512'(idx), 512'(32));
        chk("wide_ndone", 512'(ndone), 512'(1));
        chk("wide_done_cycle", 512'(done_cyc), 512'(225));
        chk("wide_busy_after", 512'(busy_w), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
